div_sqrt_sequencer: RTL
=======================

Name: div_sqrt_sequencer

Overview:
- Control FSM for the iterative divide/square-root unit of the FPU.
- Accepts one operation at a time and loads operands into the datapath.
- Sequences the radix-2 iteration steps, then normalize and round.
- Drives the exponent select for the result exponent mux and presents the finished result through a valid/ack handshake.
- Special-case operands, as flagged by the upstream classifier, bypass iteration entirely.

Parameters:
- ITERATIONS, 26, radix-2 quotient/root steps per operation: 24 mantissa bits + guard + round.
- COUNT_WIDTH, 5, width of the iteration counter; must satisfy 2^COUNT_WIDTH >= ITERATIONS.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; accepted only when ready=1.
- operation  input  1  0 = divide, 1 = sqrt; sampled on accept.
- special_case  input  1  classifier says the result needs no iteration; sampled on accept.
- special_exponent_select  input  exponent::exponent_select  exponent source for the special result; sampled on accept.
- exponent_overflow  input  1  rounding stage overflow; sampled in ROUND.
- exponent_underflow  input  1  rounding stage underflow; sampled in ROUND.
- result_ack  input  1  downstream accepts the result.
- flush  input  1  synchronous abort.
- ready  output  1  sequencer idle, start will be accepted.
- busy  output  1  operation in progress (any state except IDLE).
- load  output  1  datapath latches operands.
- iteration_enable  output  1  datapath performs one iteration step.
- normalize  output  1  datapath normalize step.
- round  output  1  datapath round step.
- operation_latched  output  1  operation captured on accept.
- iteration_count  output  COUNT_WIDTH  current iteration index.
- exponent_select  output  exponent::exponent_select  drives the result exponent mux.
- valid_out  output  1  result available.

Behaviour:
- States: IDLE, LOAD, ITERATE, NORMALIZE, ROUND, DONE.
- All outputs decode from registered state only; there are no combinational input-to-output paths.
- Reset (reset_n low, asynchronous):
  - state=IDLE; ready=1.
  - busy, load, iteration_enable, normalize, round, valid_out, operation_latched = 0.
  - iteration_count=0; exponent_select=ZEROS.
  - Internal flags: special, ovf, unf = 0.
- Reset mid-operation discards the operation; valid_out is never raised for it.
- IDLE:
  - Accept when start=1: latch operation, special_case and special_exponent_select.
  - special_case=1 -> DONE; otherwise -> LOAD.
  - start=0 -> stay in IDLE.
- LOAD: load=1 for 1 cycle; iteration_count<=0; -> ITERATE.
- ITERATE:
  - iteration_enable=1 each cycle; iteration_count increments each cycle.
  - Leave to NORMALIZE after the cycle where iteration_count==ITERATIONS-1, giving exactly ITERATIONS enable cycles.
  - iteration_count holds its final value afterwards.
  - Sqrt uses the same count.
- NORMALIZE: normalize=1 for 1 cycle; -> ROUND.
- ROUND: round=1 for 1 cycle; latch ovf<=exponent_overflow and unf<=exponent_underflow; -> DONE.
- DONE:
  - valid_out=1; hold all result controls stable until result_ack=1, then -> IDLE.
  - exponent_select in DONE:
    - special path: latched special_exponent_select.
    - normal path: ONES if ovf; else ZEROS if unf; else RESULT. Overflow wins if both are set.
- Outside DONE, exponent_select=RESULT (ZEROS only out of reset, until the first accept).
- Latency, accept at cycle T:
  - normal: load at T+1, iteration_enable T+2..T+1+ITERATIONS, normalize T+2+ITERATIONS, round T+3+ITERATIONS, valid_out from T+4+ITERATIONS (T+30 at default).
  - special: valid_out from T+1.
- Boundaries:
  - start while ready=0 is ignored, not queued, including start during DONE.
  - result_ack outside DONE is ignored.
  - ack in the first DONE cycle is honoured: ready=1 on the next cycle.
  - No back-to-back accept from DONE; IDLE is always visited.
- flush:
  - From any state: -> IDLE next cycle; valid_out drops; latched flags cleared.
  - flush has priority over start and result_ack.
  - flush in IDLE is a no-op, and a simultaneous start is dropped.

Test Plan:
1. Reset then idle: reset_n low -> ready=1, busy=0, valid_out=0, exponent_select=ZEROS. Release with start=0 -> all outputs stable for 10 cycles.
2. Normal divide: start=1, operation=0, special_case=0 at cycle 0 ->
   - load at cycle 1; iteration_enable cycles 2-27 (26 pulses, count 0..25).
   - normalize at 28; round at 29; valid_out at 30 with exponent_select=RESULT.
   - ack at 32 -> ready=1 at 33.
3. Special sqrt: start=1, operation=1, special_case=1, special_exponent_select=ONES ->
   - valid_out at cycle 1, exponent_select=ONES, operation_latched=1.
   - load and iteration_enable never asserted.
4. Range flags in ROUND:
   - overflow=1 -> DONE exponent_select=ONES.
   - underflow=1 only -> ZEROS.
   - both=1 -> ONES.
   - flags asserted outside ROUND -> RESULT.
5. Backpressure: result_ack low 5 cycles in DONE -> valid_out and exponent_select unchanged. start pulses during DONE are ignored, with no second load. Ack -> IDLE.
6. Abort/reset mid-op:
   - flush at iteration_count=10 -> IDLE next cycle, no valid_out; a new start then gives full 30-cycle latency.
   - reset_n low mid-ITERATE -> immediate reset values.

Source files
------------

// File: rtl/div_sqrt_sequencer.sv
// div_sqrt_sequencer: control FSM for the iterative radix-2 divide/sqrt unit.
// Rev 1.0 - initial release.
`default_nettype none

package exponent;
  typedef enum logic [1:0] {
    ZEROS  = 2'd0,
    ONES   = 2'd1,
    RESULT = 2'd2
  } exponent_select;
endpackage

module div_sqrt_sequencer #(
  parameter int ITERATIONS  = 26,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      operation,
  input  logic                      special_case,
  input  exponent::exponent_select  special_exponent_select,
  input  logic                      exponent_overflow,
  input  logic                      exponent_underflow,
  input  logic                      result_ack,
  input  logic                      flush,
  output logic                      ready,
  output logic                      busy,
  output logic                      load,
  output logic                      iteration_enable,
  output logic                      normalize,
  output logic                      round,
  output logic                      operation_latched,
  output logic [COUNT_WIDTH-1:0]    iteration_count,
  output exponent::exponent_select  exponent_select,
  output logic                      valid_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] ITERATE   = 3'd2;
  localparam logic [2:0] NORMALIZE = 3'd3;
  localparam logic [2:0] ROUND     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(ITERATIONS - 1);

  logic [2:0]               state;
  logic                     special;
  logic                     ovf;
  logic                     unf;
  logic                     started;
  exponent::exponent_select special_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      special           <= 1'b0;
      ovf               <= 1'b0;
      unf               <= 1'b0;
      started           <= 1'b0;
      special_sel       <= exponent::ZEROS;
      operation_latched <= 1'b0;
      iteration_count   <= '0;
    end else if (flush) begin
      state   <= IDLE;
      special <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            operation_latched <= operation;
            special           <= special_case;
            special_sel       <= special_exponent_select;
            ovf               <= 1'b0;
            unf               <= 1'b0;
            started           <= 1'b1;
            state             <= special_case ? DONE : LOAD;
          end
        end
        LOAD: begin
          iteration_count <= '0;
          state           <= ITERATE;
        end
        ITERATE: begin
          // The count stops on the last step so it stays visible after iteration.
          if (iteration_count == LAST_COUNT) begin
            state <= NORMALIZE;
          end else begin
            iteration_count <= iteration_count + COUNT_WIDTH'(1);
          end
        end
        NORMALIZE: state <= ROUND;
        ROUND: begin
          ovf   <= exponent_overflow;
          unf   <= exponent_underflow;
          state <= DONE;
        end
        DONE: begin
          if (result_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready            = (state == IDLE);
  assign busy             = (state != IDLE);
  assign load             = (state == LOAD);
  assign iteration_enable = (state == ITERATE);
  assign normalize        = (state == NORMALIZE);
  assign round            = (state == ROUND);
  assign valid_out        = (state == DONE);

  // Overflow takes precedence over underflow when both were flagged in ROUND.
  always_comb begin
    exponent_select = started ? exponent::RESULT : exponent::ZEROS;
    if (state == DONE) begin
      if (special)  exponent_select = special_sel;
      else if (ovf) exponent_select = exponent::ONES;
      else if (unf) exponent_select = exponent::ZEROS;
      else          exponent_select = exponent::RESULT;
    end
  end

endmodule

`default_nettype wire
